// File: rtl/wl_core_data_demux.sv
// Routes Snitch core LSU reqrsp traffic to the data memory, CSR and HWPE config targets by address.
// Optional sticky decode-error log is built when WL_DEMUX_ERR_LOG_EN is defined.
module wl_core_data_demux #(
  parameter int unsigned          AddrWidth      = 32,
  parameter int unsigned          DataWidth      = 32,
  parameter int unsigned          MaxOutstanding = 4,
  parameter logic [AddrWidth-1:0] DataMemBase    = 32'h0002_0000,
  parameter logic [AddrWidth-1:0] DataMemSize    = 32'h0000_4000,
  parameter logic [AddrWidth-1:0] CsrBase        = 32'h0004_0000,
  parameter logic [AddrWidth-1:0] CsrSize        = 32'h0000_0004,
  parameter logic [AddrWidth-1:0] HwpeCfgBase    = 32'h0008_0000,
  parameter logic [AddrWidth-1:0] HwpeCfgSize    = 32'h0000_1000
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          slv_q_valid_i,
  output logic                          slv_q_ready_o,
  input  logic [AddrWidth-1:0]          slv_q_addr_i,
  input  logic                          slv_q_write_i,
  input  logic [DataWidth-1:0]          slv_q_data_i,
  input  logic [DataWidth/8-1:0]        slv_q_strb_i,
  output logic                          slv_p_valid_o,
  input  logic                          slv_p_ready_i,
  output logic [DataWidth-1:0]          slv_p_data_o,
  output logic                          slv_p_error_o,
  output logic [2:0]                    mst_q_valid_o,
  input  logic [2:0]                    mst_q_ready_i,
  output logic [AddrWidth-1:0]          mst_q_addr_o,
  output logic                          mst_q_write_o,
  output logic [DataWidth-1:0]          mst_q_data_o,
  output logic [DataWidth/8-1:0]        mst_q_strb_o,
  input  logic [2:0]                    mst_p_valid_i,
  output logic [2:0]                    mst_p_ready_o,
  input  logic [2:0][DataWidth-1:0]     mst_p_data_i,
  input  logic [2:0]                    mst_p_error_i,
  output logic                          err_valid_o,
  output logic [AddrWidth-1:0]          err_addr_o,
  input  logic                          err_clear_i
);

  localparam int unsigned          CntW    = $clog2(MaxOutstanding + 1);
  localparam logic [CntW-1:0]      CntMax  = CntW'(MaxOutstanding);
  localparam logic [CntW-1:0]      CntOne  = CntW'(1);
  localparam logic [AddrWidth-1:0] AddrOne = AddrWidth'(1);
  localparam logic [1:0]           TgtErr  = 2'd3;

  function automatic logic addr_hit(input logic [AddrWidth-1:0] addr,
                                    input logic [AddrWidth-1:0] base,
                                    input logic [AddrWidth-1:0] size);
    return (addr & ~(size - AddrOne)) == base;
  endfunction

  logic [1:0]      dec;
  logic [1:0]      cur_tgt_q;
  logic [CntW-1:0] cnt_q;
  logic            err_pend_q;
  logic            issue_ok;
  logic            accept;
  logic            acc_map;
  logic            acc_err;
  logic            rsp_live;
  logic            rsp_hs;

  always_comb begin
    dec = TgtErr;
    if (addr_hit(slv_q_addr_i, DataMemBase, DataMemSize)) begin
      dec = 2'd0;
    end else if (addr_hit(slv_q_addr_i, CsrBase, CsrSize)) begin
      dec = 2'd1;
    end else if (addr_hit(slv_q_addr_i, HwpeCfgBase, HwpeCfgSize)) begin
      dec = 2'd2;
    end
  end

  // A new target may only be opened once every earlier transaction has drained,
  // which is what keeps responses in request order without a reorder buffer.
  always_comb begin
    issue_ok = 1'b0;
    if (!err_pend_q) begin
      if (dec == TgtErr) begin
        issue_ok = (cnt_q == '0);
      end else begin
        issue_ok = (cnt_q == '0) || ((dec == cur_tgt_q) && (cnt_q < CntMax));
      end
    end
  end

  always_comb begin
    mst_q_valid_o = '0;
    slv_q_ready_o = 1'b0;
    if (issue_ok) begin
      if (dec == TgtErr) begin
        slv_q_ready_o = 1'b1;
      end else begin
        for (int i = 0; i < 3; i++) begin
          if (dec == 2'(i)) begin
            mst_q_valid_o[i] = slv_q_valid_i;
            slv_q_ready_o    = mst_q_ready_i[i];
          end
        end
      end
    end
  end

  assign mst_q_addr_o  = slv_q_addr_i;
  assign mst_q_write_o = slv_q_write_i;
  assign mst_q_data_o  = slv_q_data_i;
  assign mst_q_strb_o  = slv_q_strb_i;

  assign accept  = slv_q_valid_i & slv_q_ready_o;
  assign acc_map = accept & (dec != TgtErr);
  assign acc_err = accept & (dec == TgtErr);

  // Stray target responses with nothing outstanding are left unacknowledged.
  assign rsp_live = !err_pend_q && (cnt_q != '0) && (cur_tgt_q != TgtErr);

  always_comb begin
    mst_p_ready_o = '0;
    slv_p_valid_o = 1'b0;
    slv_p_data_o  = '0;
    slv_p_error_o = 1'b0;
    if (err_pend_q) begin
      slv_p_valid_o = 1'b1;
      slv_p_error_o = 1'b1;
    end else if (rsp_live) begin
      for (int i = 0; i < 3; i++) begin
        if (cur_tgt_q == 2'(i)) begin
          slv_p_valid_o    = mst_p_valid_i[i];
          mst_p_ready_o[i] = slv_p_ready_i;
          slv_p_data_o     = mst_p_data_i[i];
          slv_p_error_o    = mst_p_error_i[i];
        end
      end
    end
  end

  assign rsp_hs = rsp_live & slv_p_valid_o & slv_p_ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cur_tgt_q  <= 2'd0;
      cnt_q      <= '0;
      err_pend_q <= 1'b0;
    end else begin
      if (accept) begin
        cur_tgt_q <= dec;
      end
      if (acc_map && !rsp_hs) begin
        cnt_q <= cnt_q + CntOne;
      end else if (rsp_hs && !acc_map) begin
        cnt_q <= cnt_q - CntOne;
      end
      if (acc_err) begin
        err_pend_q <= 1'b1;
      end else if (err_pend_q && slv_p_ready_i) begin
        err_pend_q <= 1'b0;
      end
    end
  end

`ifdef WL_DEMUX_ERR_LOG_EN
  logic                 err_valid_q;
  logic [AddrWidth-1:0] err_addr_q;

  // A fresh fault beats a simultaneous clear so it is never lost.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_valid_q <= 1'b0;
      err_addr_q  <= '0;
    end else if (acc_err && (!err_valid_q || err_clear_i)) begin
      err_valid_q <= 1'b1;
      err_addr_q  <= slv_q_addr_i;
    end else if (err_clear_i) begin
      err_valid_q <= 1'b0;
      err_addr_q  <= '0;
    end
  end

  assign err_valid_o = err_valid_q;
  assign err_addr_o  = err_addr_q;
`else
  logic unused_err_clear;
  assign unused_err_clear = err_clear_i;
  assign err_valid_o      = 1'b0;
  assign err_addr_o       = '0;
`endif

endmodule

// File: doc/wl_core_data_demux.md
Name: wl_core_data_demux

Overview:
- Sits directly downstream of the Snitch core LSU reqrsp port (core_data_req_t/core_data_rsp_t).
- Routes each request to one of three Wakelet LSU targets by address: data memory (idx 0), CSR block (idx 1), HWPE config port (idx 2).
- Preserves response order by tracking outstanding transactions.
- Unmapped addresses go to an internal error responder.

Parameters:
- AddrWidth, 32, address width.
- DataWidth, 32, data width; strobe width is DataWidth/8.
- MaxOutstanding, 4, maximum in-flight requests toward a single target.
- DataMemBase, 32'h0002_0000, target 0 base.
- DataMemSize, 32'h0000_4000, target 0 size in bytes (NAPOT).
- CsrBase, 32'h0004_0000, target 1 base.
- CsrSize, 32'h0000_0004, target 1 size.
- HwpeCfgBase, 32'h0008_0000, target 2 base.
- HwpeCfgSize, 32'h0000_1000, target 2 size.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous reset, active-high.
- slv_q_valid_i  in  1  core request valid.
- slv_q_ready_o  out  1  core request ready.
- slv_q_addr_i  in  AddrWidth  request address.
- slv_q_write_i  in  1  1 = write.
- slv_q_data_i  in  DataWidth  write data.
- slv_q_strb_i  in  DataWidth/8  write strobes.
- slv_p_valid_o  out  1  response valid.
- slv_p_ready_i  in  1  response ready.
- slv_p_data_o  out  DataWidth  read data.
- slv_p_error_o  out  1  response error.
- mst_q_valid_o  out  3  per-target request valid.
- mst_q_ready_i  in  3  per-target request ready.
- mst_q_addr_o  out  AddrWidth  broadcast address.
- mst_q_write_o  out  1  broadcast write.
- mst_q_data_o  out  DataWidth  broadcast write data.
- mst_q_strb_o  out  DataWidth/8  broadcast strobes.
- mst_p_valid_i  in  3  per-target response valid.
- mst_p_ready_o  out  3  per-target response ready.
- mst_p_data_i  in  3xDataWidth  per-target read data.
- mst_p_error_i  in  3  per-target error.
- err_valid_o  out  1  sticky decode-error flag (optional feature).
- err_addr_o  out  AddrWidth  first faulting address (optional feature).
- err_clear_i  in  1  clears the error log (optional feature).

Behaviour:
- Decode is combinational on slv_q_addr_i: hit(i) = (addr & ~(Size_i-1)) == Base_i. No hit selects the error target (idx 3).
- Tracking registers:
  - cur_tgt_q: 2 bits, reset 0.
  - cnt_q: $clog2(MaxOutstanding+1) bits, reset 0.
- Request issue is allowed when cnt_q==0, or when (dec==cur_tgt_q and cnt_q<MaxOutstanding).
- Otherwise the request is stalled: all mst_q_valid_o=0, slv_q_ready_o=0.
- When issue is allowed for a real target: mst_q_valid_o[dec]=slv_q_valid_i and slv_q_ready_o=mst_q_ready_i[dec]. Other valids stay 0.
- Accept = slv_q_valid_i & slv_q_ready_o. On accept, cur_tgt_q<=dec.
- Response channel is a combinational mux from cur_tgt_q:
  - slv_p_valid_o=mst_p_valid_i[cur_tgt_q]; mst_p_ready_o[cur_tgt_q]=slv_p_ready_i; other readies 0.
  - Data and error come from the same target.
  - Response mux is live only while cnt_q>0. A response arriving with cnt_q==0 is not acknowledged.
- Counter update:
  - Accept and no response handshake: cnt_q+1.
  - Response handshake and no accept: cnt_q-1.
  - Both in the same cycle: cnt_q unchanged.
  - Never wraps: issue is blocked at MaxOutstanding, and decrement is impossible at 0.
- Error responder:
  - One-entry register, err_pend_q, reset 0.
  - Accepts an unmapped request only when cnt_q==0 and err_pend_q==0. slv_q_ready_o=1 in that case.
  - Next cycle: slv_p_valid_o=1, slv_p_data_o=0, slv_p_error_o=1, held until slv_p_ready_i.
  - While err_pend_q=1, all requests are stalled.
- Same-cycle rules:
  - Request and response are accepted in the same cycle only to the same target.
  - A new unmapped request cannot overlap any outstanding transaction.
- Reset values: all mst_q_valid_o=0, slv_p_valid_o=0, slv_q_ready_o=0 until decode permits, err_valid_o=0, err_addr_o=0.
- Reset mid-operation clears cnt_q and err_pend_q; in-flight responses are discarded. System-level reset is applied to targets together with this block.
- Latency: zero added cycles on both request and response for mapped targets; one cycle for the error response.

Optional Feature:
- Macro: WL_DEMUX_ERR_LOG_EN.
- When defined:
  - On the first unmapped accept while err_valid_o==0, capture the address into err_addr_o and set err_valid_o=1.
  - Later errors do not overwrite the log.
  - err_clear_i=1 clears both registers next cycle. If clear coincides with a new error, the new error wins and is captured.
- When undefined: err_valid_o and err_addr_o are tied to 0, err_clear_i is ignored, and no registers are inferred.

Test Plan:
- Read 0x0002_0010, target 0 returns data 0xDEAD_BEEF one cycle later -> only mst_q_valid_o[0] asserted; slv_p_data_o=0xDEAD_BEEF, error=0; cnt returns to 0.
- Four back-to-back writes to 0x0004_0000 with target 1 holding responses -> 4 accepted; a 5th is stalled with ready=0 until one response handshakes.
- Read 0x0002_0000 outstanding, then read 0x0008_0000 -> HWPE request held until the DataMem response completes; responses arrive in order.
- Read 0x0010_0000 (unmapped) -> ready=1, next cycle p_valid=1, error=1, data=0. With WL_DEMUX_ERR_LOG_EN: err_addr_o=0x0010_0000, err_valid_o=1. A second fault to 0x0020_0000 keeps 0x0010_0000; err_clear_i clears the log.
- Same-cycle accept and response on target 0 with cnt=2 -> cnt stays 2.
- Assert rst_i with cnt=3 -> next cycle cnt=0, all valids 0; a request to 0x0008_0000 issues immediately.
